// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, drives datapath strobes, counts retirements, traps on faults.
module multicycle_seq #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          Opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                RegDest,
  output logic                ALUSrc,
  output logic                Sig_Mem_Read,
  output logic                Sig_Mem_Write,
  output logic                Sig_Mem_to_Reg,
  output logic                Sig_Reg_Write,
  output logic [2:0]          ALUOp,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic [3:0]          state,
  output logic [1:0]          err_code,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAddr   = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbR    = 4'd7,
    StWbI    = 4'd8,
    StWbMem  = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd15
  } state_e;

  localparam logic [7:0] TimeoutLim = 8'(MEM_TIMEOUT);

  state_e              r_state;
  logic [7:0]          r_wait_cnt;
  logic [3:0]          r_opcode;
  logic [1:0]          r_err;
  logic [RETIRE_W-1:0] r_retired;

  state_e     w_state_d;
  logic [1:0] w_err_d;
  logic       w_retire;
  logic       w_timeout;
  logic       w_is_wait;
  logic [7:0] w_wait_d;

  assign w_timeout = (r_wait_cnt == TimeoutLim) && !mem_ready;
  assign w_is_wait = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  // Counter runs only while parked in a memory state; any state change clears it.
  assign w_wait_d  = (w_is_wait && (w_state_d == r_state)) ? r_wait_cnt + 8'd1 : 8'd0;

  // State register and datapath-side bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StFetch;
      r_wait_cnt <= 8'd0;
      r_opcode   <= 4'd0;
      r_err      <= 2'b00;
      r_retired  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_d;
      r_err      <= w_err_d;
      if (r_state == StDecode) r_opcode <= Opcode;
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_err_d   = r_err;
    w_retire  = 1'b0;
    case (r_state)
      StFetch: begin
        if (mem_ready) begin
          w_state_d = StDecode;
        end else if (w_timeout) begin
          w_state_d = StTrap;
          w_err_d   = 2'b10;
        end
      end
      StDecode: begin
        case (Opcode)
          4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011: w_state_d = StExecR;
          4'b0111:                                      w_state_d = StExecI;
          4'b1000, 4'b1010:                             w_state_d = StAddr;
          4'b1110:                                      w_state_d = StBranch;
          4'b1111:                                      w_state_d = StJump;
          default: begin
            w_state_d = StTrap;
            w_err_d   = 2'b01;
          end
        endcase
      end
      StExecR: w_state_d = StWbR;
      StExecI: w_state_d = StWbI;
      // Only ld (1000) and sd (1010) reach here; bit 1 tells them apart.
      StAddr:  w_state_d = r_opcode[1] ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          w_state_d = StWbMem;
        end else if (w_timeout) begin
          w_state_d = StTrap;
          w_err_d   = 2'b10;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          w_state_d = StFetch;
          w_retire  = 1'b1;
        end else if (w_timeout) begin
          w_state_d = StTrap;
          w_err_d   = 2'b10;
        end
      end
      StWbR, StWbI, StWbMem, StBranch, StJump: begin
        w_state_d = StFetch;
        w_retire  = 1'b1;
      end
      StTrap:  w_state_d = StTrap;
      default: w_state_d = StFetch;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    RegDest        = 1'b0;
    ALUSrc         = 1'b0;
    Sig_Mem_Read   = 1'b0;
    Sig_Mem_Write  = 1'b0;
    Sig_Mem_to_Reg = 1'b0;
    Sig_Reg_Write  = 1'b0;
    ALUOp          = 3'b000;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 2'b00;
    iord           = 1'b0;
    if (rst_n) begin
      case (r_state)
        StFetch: begin
          Sig_Mem_Read = 1'b1;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
        end
        StExecR: begin
          case (r_opcode)
            4'b0110: ALUOp = 3'b001;
            4'b0000: ALUOp = 3'b010;
            4'b0001: ALUOp = 3'b011;
            4'b0011: ALUOp = 3'b100;
            default: ALUOp = 3'b000;
          endcase
        end
        StExecI: begin
          ALUSrc = 1'b1;
          ALUOp  = 3'b101;
        end
        StAddr:  ALUSrc = 1'b1;
        StMemRd: begin
          Sig_Mem_Read = 1'b1;
          iord         = 1'b1;
        end
        StMemWr: begin
          Sig_Mem_Write = 1'b1;
          iord          = 1'b1;
        end
        StWbR: begin
          Sig_Reg_Write = 1'b1;
          RegDest       = 1'b1;
        end
        StWbI:   Sig_Reg_Write = 1'b1;
        StWbMem: begin
          Sig_Reg_Write  = 1'b1;
          Sig_Mem_to_Reg = 1'b1;
        end
        StBranch: begin
          ALUOp    = 3'b001;
          pc_src   = 2'b01;
          pc_write = ~zero;
        end
        StJump: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state    = r_state;
  assign err_code = r_err;
  assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: per-cycle expected state/strobes are queued
// as stimulus is driven and compared against the DUT mid-cycle.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Opcode;
  logic        zero;
  logic        mem_ready;
  logic        RegDest, ALUSrc, Sig_Mem_Read, Sig_Mem_Write, Sig_Mem_to_Reg, Sig_Reg_Write;
  logic [2:0]  ALUOp;
  logic        ir_write, pc_write, iord;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  logic [1:0]  err_code;
  logic [31:0] retired;
  logic [13:0] ctl;

  multicycle_seq #(.MEM_TIMEOUT(15), .RETIRE_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Opcode         (Opcode),
    .zero           (zero),
    .mem_ready      (mem_ready),
    .RegDest        (RegDest),
    .ALUSrc         (ALUSrc),
    .Sig_Mem_Read   (Sig_Mem_Read),
    .Sig_Mem_Write  (Sig_Mem_Write),
    .Sig_Mem_to_Reg (Sig_Mem_to_Reg),
    .Sig_Reg_Write  (Sig_Reg_Write),
    .ALUOp          (ALUOp),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .iord           (iord),
    .state          (state),
    .err_code       (err_code),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  assign ctl = {RegDest, ALUSrc, Sig_Mem_Read, Sig_Mem_Write, Sig_Mem_to_Reg, Sig_Reg_Write,
                ALUOp, ir_write, pc_write, pc_src, iord};

  typedef struct {
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [1:0]  err;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  cur_op   = 4'd0;
  logic [1:0]  exp_err  = 2'b00;
  logic [31:0] exp_ret  = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  // Expected strobes from the state table, given the instruction being executed.
  function automatic logic [13:0] ctl_of(input logic [3:0] st, input logic rdy,
                                         input logic z, input logic [3:0] op);
    logic rd, as, mr, mw, m2r, rw, irw, pcw, io;
    logic [2:0] alu;
    logic [1:0] ps;
    {rd, as, mr, mw, m2r, rw, irw, pcw, io} = '0;
    alu = 3'b000;
    ps  = 2'b00;
    case (st)
      4'd0:  begin mr = 1'b1; irw = rdy; pcw = rdy; end
      4'd2:  case (op)
               4'b0110: alu = 3'b001;
               4'b0000: alu = 3'b010;
               4'b0001: alu = 3'b011;
               4'b0011: alu = 3'b100;
               default: alu = 3'b000;
             endcase
      4'd3:  begin as = 1'b1; alu = 3'b101; end
      4'd4:  as = 1'b1;
      4'd5:  begin mr = 1'b1; io = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  rw = 1'b1;
      4'd9:  begin rw = 1'b1; m2r = 1'b1; end
      4'd10: begin alu = 3'b001; ps = 2'b01; pcw = ~z; end
      4'd11: begin pcw = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {rd, as, mr, mw, m2r, rw, alu, irw, pcw, ps, io};
  endfunction

  // Called at a falling edge: drive, queue the expectation, compare, advance one cycle.
  task automatic step(input logic [3:0] st, input logic rdy, input logic z,
                      input logic [3:0] op, input logic ret);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    Opcode    = op;
    e.st  = st;
    e.ctl = ctl_of(st, rdy, z, cur_op);
    e.err = exp_err;
    e.ret = exp_ret;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check_eq($sformatf("state(exp %0d)", e.st), 32'(state), 32'(e.st));
    check_eq($sformatf("ctl(st %0d)", e.st), 32'(ctl), 32'(e.ctl));
    check_eq($sformatf("err(st %0d)", e.st), 32'(err_code), 32'(e.err));
    check_eq($sformatf("retired(st %0d)", e.st), retired, e.ret);
    if (ret) exp_ret++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("rst_ctl_forced", 32'(ctl), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ret = 32'd0;
    exp_err = 2'b00;
  endtask

  initial begin
    logic [3:0] r_ops [5];
    r_ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011};
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; Opcode = 4'd0;
    @(negedge clk);
    do_reset();

    // R-type, live opcode scrambled after DECODE to prove the latch is used
    foreach (r_ops[k]) begin
      cur_op = r_ops[k];
      step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
      step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
      step(4'd2, 1'b1, 1'b0, 4'b1111, 1'b0);
      step(4'd7, 1'b1, 1'b0, 4'b1111, 1'b1);
    end

    // ldi
    cur_op = 4'b0111;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd3, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd8, 1'b1, 1'b0, cur_op, 1'b1);

    // ld with three data waits; live opcode looks like sd during ADDR
    cur_op = 4'b1000;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd4, 1'b1, 1'b0, 4'b1010, 1'b0);
    step(4'd5, 1'b0, 1'b0, 4'b1010, 1'b0);
    step(4'd5, 1'b0, 1'b0, 4'b1010, 1'b0);
    step(4'd5, 1'b0, 1'b0, 4'b1010, 1'b0);
    step(4'd5, 1'b1, 1'b0, 4'b1010, 1'b0);
    step(4'd9, 1'b1, 1'b0, 4'b1010, 1'b1);

    // sd zero-wait
    cur_op = 4'b1010;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd4, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd6, 1'b1, 1'b0, cur_op, 1'b1);

    // bne taken then not taken, preceded by a fetch with two waits
    cur_op = 4'b1110;
    step(4'd0, 1'b0, 1'b0, cur_op, 1'b0);
    step(4'd0, 1'b0, 1'b0, cur_op, 1'b0);
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd10, 1'b1, 1'b0, cur_op, 1'b1);
    step(4'd0, 1'b1, 1'b1, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b1, cur_op, 1'b0);
    step(4'd10, 1'b1, 1'b1, cur_op, 1'b1);

    // jmp
    cur_op = 4'b1111;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd11, 1'b1, 1'b0, cur_op, 1'b1);

    // Illegal opcode: sticky trap regardless of mem_ready
    cur_op = 4'b0100;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    exp_err = 2'b01;
    for (int i = 0; i < 20; i++) step(4'd15, (i % 2) == 1, 1'b0, cur_op, 1'b0);
    do_reset();

    // Fetch timeout after exactly 16 cycles
    cur_op = 4'b1111;
    for (int i = 0; i < 16; i++) step(4'd0, 1'b0, 1'b0, cur_op, 1'b0);
    exp_err = 2'b10;
    step(4'd15, 1'b0, 1'b0, cur_op, 1'b0);
    do_reset();

    // Ready on the limit cycle completes the fetch
    for (int i = 0; i < 15; i++) step(4'd0, 1'b0, 1'b0, cur_op, 1'b0);
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd11, 1'b1, 1'b0, cur_op, 1'b1);

    // Data-read timeout
    cur_op = 4'b1000;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd4, 1'b1, 1'b0, cur_op, 1'b0);
    for (int i = 0; i < 16; i++) step(4'd5, 1'b0, 1'b0, cur_op, 1'b0);
    exp_err = 2'b10;
    step(4'd15, 1'b0, 1'b0, cur_op, 1'b0);
    do_reset();

    // sd aborted by reset mid-write
    cur_op = 4'b1010;
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd1, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd4, 1'b1, 1'b0, cur_op, 1'b0);
    step(4'd6, 1'b0, 1'b0, cur_op, 1'b0);
    do_reset();
    step(4'd0, 1'b0, 1'b0, cur_op, 1'b0);
    step(4'd0, 1'b1, 1'b0, cur_op, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
